lsu_mem_master: RTL and testbench
=================================

# lsu_mem_master

Load/store initiator that sits between the execute/memory pipeline stage and the single-port word-addressed data memory (`WE`/`A`/`WD`/`RD`, synchronous write, asynchronous read). It accepts byte, halfword and word load/store requests over a valid/ready handshake. It performs read-modify-write for sub-word stores and sign- or zero-extends sub-word loads. It returns exactly one response per accepted request.

## Interface
- `DATA_WIDTH`, 32, data word width; only 32 is supported.
- `ADDR_WIDTH`, 32, byte address width.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; forces IDLE immediately.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  block can accept; 1 only in IDLE with `reset` low.
- `req_we`  in  1  1 = store, 0 = load.
- `req_size`  in  2  00 byte, 01 halfword, 10 word; 11 is illegal.
- `req_unsigned`  in  1  load zero-extends when 1, sign-extends when 0.
- `req_addr`  in  ADDR_WIDTH  byte address.
- `req_wdata`  in  DATA_WIDTH  store data, right-aligned (the byte is in [7:0], the halfword in [15:0]).
- `rsp_valid`  out  1  one-cycle response pulse.
- `rsp_rdata`  out  DATA_WIDTH  extended load data; 0 for stores and errors.
- `rsp_err`  out  1  misaligned access or illegal size; qualified by `rsp_valid`.
- `mem_we`  out  1  to memory `WE`.
- `mem_a`  out  ADDR_WIDTH  to memory `A`; always word-aligned (bits [1:0] = 00).
- `mem_wd`  out  DATA_WIDTH  to memory `WD`.
- `mem_rd`  in  DATA_WIDTH  from memory `RD` (combinational).

## Operation
- States: IDLE, READ, WRITE, RESP.
- IDLE: `req_ready`=1. When `req_valid`=1, the block latches `req_*` into internal registers and transitions:
  - load, or sub-word store → READ
  - word store → WRITE
  - misaligned or illegal access → RESP with the error flag set
- Misalignment rules:
  - a halfword is misaligned when `addr[0]`=1
  - a word is misaligned when `addr[1:0]`≠00
  - a byte is never misaligned
  - `req_size`=11 is always an error
  - an error causes no memory access of any kind
- READ: drives `mem_a` = {addr[ADDR_WIDTH-1:2], 2'b00} with `mem_we`=0, and captures `mem_rd` into the word register.
  - load → RESP
  - sub-word store → WRITE
- WRITE: drives `mem_a` and `mem_we`=1 for exactly one cycle, then → RESP. `mem_wd` is:
  - word store: `req_wdata`
  - byte store: the captured word with lane `addr[1:0]` (little-endian, lane n = bits [8n+7:8n]) replaced by `wdata[7:0]`
  - halfword store: the captured word with bits [15:0] (`addr[1]`=0) or [31:16] (`addr[1]`=1) replaced by `wdata[15:0]`
- RESP: `rsp_valid`=1 for one cycle, then → IDLE.
  - load: `rsp_rdata` = the selected lane, extended per `req_unsigned`
  - store: `rsp_rdata`=0
  - `rsp_err` = latched error flag
- `rsp_valid` has no backpressure; the consumer must take the response in that cycle.
- Outside the READ and WRITE states, `mem_we`=0 and `mem_a`/`mem_wd` hold their last values; their content is don't-care.
- Request inputs are sampled only on the acceptance edge; later changes have no effect.

## Timing
- Acceptance at edge 0. Response (`rsp_valid`) is high during:
  - cycle 2 for a load
  - cycle 2 for a word store
  - cycle 3 for a sub-word store
  - cycle 1 for an error
- The memory write commits at the edge that ends the WRITE cycle. A load issued immediately after a store therefore sees the new data.
- Back-to-back throughput: the next request is accepted in the cycle after RESP, i.e. one request per 3 / 3 / 4 / 2 cycles.
- Reset values:
  - state = IDLE
  - `req_ready`=0 while `reset`=1
  - `rsp_valid`=0, `rsp_err`=0, `rsp_rdata`=0
  - `mem_we`=0, `mem_a`=0, `mem_wd`=0
- Reset mid-operation: `mem_we` drops asynchronously, any in-flight write is abandoned (no partial write), and no response is produced. After `reset` falls, `req_ready`=1 in the first cycle.
- `req_valid` asserted during reset is ignored.

## Test plan
- Memory word 0x4 = 0x11223344; byte store to 0x5 with data 0x000000AB → READ then WRITE with `mem_a`=0x4 and `mem_wd`=0x1122AB44; `rsp_valid` in cycle 3 with `rsp_err`=0.
- Then a byte load from 0x5, signed → `rsp_rdata`=0xFFFFFFAB in cycle 2; the same load unsigned → 0x000000AB.
- Halfword load from 0x6, signed → 0x00001122; halfword store to 0x6 with data 0xBEEF → word 0x4 becomes 0xBEEFAB44.
- Word load from 0x6, and halfword store to 0x3 → `rsp_valid` with `rsp_err`=1 in cycle 1; `mem_we` never asserted and memory contents unchanged.
- Word store of 0xDEADBEEF to 0x8, with `reset` asserted during the WRITE cycle → `mem_we` falls immediately, no `rsp_valid` pulse, and `req_ready`=1 in the cycle after `reset` falls.
- Back-to-back: word store of 0xCAFEF00D to 0x10, then a word load from 0x10 issued as soon as `req_ready` rises → load returns 0xCAFEF00D; `req_ready` is low in every non-IDLE cycle.

Source files
------------

// File: rtl/lsu_mem_master_if.sv
// Request/response handshake between the pipeline and the load/store unit.
// master = pipeline side, slave = lsu_mem_master.
interface lsu_mem_master_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [1:0]            req_size;
  logic                  req_unsigned;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;

  modport master (
    output req_valid, req_we, req_size,
    output req_unsigned, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_size,
    input  req_unsigned, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/lsu_mem_master.sv
// Load/store initiator for a word-addressed single-port data memory.
// Handles sub-word stores by read-modify-write and extends sub-word loads.
module lsu_mem_master #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  lsu_mem_master_if.slave       bus,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_a,
  output logic [DATA_WIDTH-1:0] mem_wd,
  input  logic [DATA_WIDTH-1:0] mem_rd
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    RESP
  } state_t;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  state_t                state;
  logic                  l_we;
  logic                  l_uns;
  logic [1:0]            l_size;
  logic [1:0]            l_lane;
  logic [15:0]           l_wdata;
  logic                  bad;
  logic                  word_st;
  logic [ADDR_WIDTH-1:0] word_a;

  function automatic logic [DATA_WIDTH-1:0] merge(
    input logic [DATA_WIDTH-1:0] w,
    input logic [1:0]            sz,
    input logic [1:0]            lane,
    input logic [15:0]           d
  );
    logic [DATA_WIDTH-1:0] r;
    r = w;
    if (sz == SZ_B)
      r[{lane, 3'b000} +: 8] = d[7:0];
    else
      r[{lane[1], 4'b0000} +: 16] = d;
    return r;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] extend(
    input logic [DATA_WIDTH-1:0] w,
    input logic [1:0]            sz,
    input logic [1:0]            lane,
    input logic                  uns
  );
    logic [7:0]            b;
    logic [15:0]           h;
    logic [DATA_WIDTH-1:0] r;
    b = w[{lane, 3'b000} +: 8];
    h = w[{lane[1], 4'b0000} +: 16];
    unique case (1'b1)
      sz == SZ_B: r = {{24{~uns & b[7]}}, b};
      sz == SZ_H: r = {{16{~uns & h[15]}}, h};
      default:    r = w;
    endcase
    return r;
  endfunction

  assign word_a = {bus.req_addr[ADDR_WIDTH-1:2], 2'b00};
  assign word_st = bus.req_we && (bus.req_size == SZ_W);
  assign bus.req_ready = (state == IDLE) && !reset;

  always_comb begin
    bad = 1'b0;
    unique case (1'b1)
      bus.req_size == SZ_B: bad = 1'b0;
      bus.req_size == SZ_H: bad = bus.req_addr[0];
      bus.req_size == SZ_W: bad = |bus.req_addr[1:0];
      default:              bad = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      l_we          <= 1'b0;
      l_uns         <= 1'b0;
      l_size        <= 2'b00;
      l_lane        <= 2'b00;
      l_wdata       <= '0;
      mem_we        <= 1'b0;
      mem_a         <= '0;
      mem_wd        <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_err   <= 1'b0;
      bus.rsp_rdata <= '0;
    end else begin
      mem_we        <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_err   <= 1'b0;
      bus.rsp_rdata <= '0;
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            l_we    <= bus.req_we;
            l_uns   <= bus.req_unsigned;
            l_size  <= bus.req_size;
            l_lane  <= bus.req_addr[1:0];
            l_wdata <= bus.req_wdata[15:0];
            // Errors skip the memory entirely.
            if (bad) begin
              bus.rsp_valid <= 1'b1;
              bus.rsp_err   <= 1'b1;
              state         <= RESP;
            end else if (word_st) begin
              mem_a  <= word_a;
              mem_wd <= bus.req_wdata;
              mem_we <= 1'b1;
              state  <= WRITE;
            end else begin
              mem_a <= word_a;
              state <= READ;
            end
          end
        end
        READ: begin
          if (l_we) begin
            mem_wd <= merge(mem_rd, l_size, l_lane, l_wdata);
            mem_we <= 1'b1;
            state  <= WRITE;
          end else begin
            bus.rsp_valid <= 1'b1;
            bus.rsp_rdata <= extend(mem_rd, l_size, l_lane, l_uns);
            state         <= RESP;
          end
        end
        WRITE: begin
          bus.rsp_valid <= 1'b1;
          state         <= RESP;
        end
        RESP: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Directed bench for lsu_mem_master with a behavioural word memory.
// Each task drives one scenario and checks hand-computed results.
module tb_lsu_mem_master;

  logic        clk;
  logic        reset;
  logic        mem_we;
  logic [31:0] mem_a;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;
  logic        mem_init;
  logic [31:0] mem [64];

  int checks;
  int fails;

  lsu_mem_master_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

  lsu_mem_master #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk    (clk),
    .reset  (reset),
    .bus    (bus),
    .mem_we (mem_we),
    .mem_a  (mem_a),
    .mem_wd (mem_wd),
    .mem_rd (mem_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rd = mem[mem_a[7:2]];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++)
        mem[i] <= 32'h5A5A_5A00 | 32'(i);
      mem[1] <= 32'h1122_3344;
    end else if (mem_we) begin
      mem[mem_a[7:2]] <= mem_wd;
    end
  end

  task automatic do_req(
    input  logic        we,
    input  logic [1:0]  sz,
    input  logic        uns,
    input  logic [31:0] addr,
    input  logic [31:0] wd,
    output logic        rdy0,
    output int          rc,
    output logic [31:0] rd,
    output logic        er,
    output int          wcnt,
    output logic [31:0] wa,
    output logic [31:0] wdat,
    output int          busy
  );
    rc = -1; rd = 'x; er = 1'bx;
    wcnt = 0; wa = '0; wdat = '0; busy = 0;
    @(negedge clk);
    rdy0 = bus.req_ready;
    bus.req_valid    = 1'b1;
    bus.req_we       = we;
    bus.req_size     = sz;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wd;
    @(posedge clk);
    for (int c = 1; c <= 8 && rc < 0; c++) begin
      @(negedge clk);
      if (c == 1) begin
        bus.req_valid    = 1'b0;
        bus.req_we       = ~we;
        bus.req_size     = 2'b11;
        bus.req_unsigned = ~uns;
        bus.req_addr     = 32'hFFFF_FFFF;
        bus.req_wdata    = 32'h0;
      end
      if (bus.req_ready) busy++;
      if (mem_we) begin
        wcnt++;
        wa   = mem_a;
        wdat = mem_wd;
      end
      if (bus.rsp_valid) begin
        rc = c;
        rd = bus.rsp_rdata;
        er = bus.rsp_err;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 1'b0) begin
      $display("FAIL rst_ready got %b want 0", bus.req_ready); fails++;
    end
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.rsp_err !== 1'b0) begin
      $display("FAIL rst_rsp got v=%b e=%b want 0 0", bus.rsp_valid, bus.rsp_err); fails++;
    end
    checks++;
    if (bus.rsp_rdata !== 32'h0) begin
      $display("FAIL rst_rdata got %h want 0", bus.rsp_rdata); fails++;
    end
    checks++;
    if (mem_we !== 1'b0 || mem_a !== 32'h0 || mem_wd !== 32'h0) begin
      $display("FAIL rst_mem got we=%b a=%h wd=%h want 0", mem_we, mem_a, mem_wd); fails++;
    end
    reset = 1'b0;
    mem_init = 1'b0;
    #1;
    checks++;
    if (bus.req_ready !== 1'b1) begin
      $display("FAIL rst_release_ready got %b want 1", bus.req_ready); fails++;
    end
  endtask

  task automatic test_byte_store();
    logic r0, er; int rc, wc, bz; logic [31:0] rd, wa, wd;
    do_req(1'b1, 2'b00, 1'b0, 32'h5, 32'h0000_00AB, r0, rc, rd, er, wc, wa, wd, bz);
    checks++;
    if (r0 !== 1'b1) begin $display("FAIL bst_ready got %b want 1", r0); fails++; end
    checks++;
    if (rc !== 3 || er !== 1'b0 || rd !== 32'h0) begin
      $display("FAIL bst_rsp got cyc=%0d err=%b rd=%h want 3 0 0", rc, er, rd); fails++;
    end
    checks++;
    if (wc !== 1 || wa !== 32'h4 || wd !== 32'h1122_AB44) begin
      $display("FAIL bst_write got n=%0d a=%h wd=%h want 1 4 1122ab44", wc, wa, wd); fails++;
    end
    checks++;
    if (mem[1] !== 32'h1122_AB44) begin
      $display("FAIL bst_mem got %h want 1122ab44", mem[1]); fails++;
    end
    checks++;
    if (bz !== 0) begin $display("FAIL bst_busy_ready got %0d want 0", bz); fails++; end
  endtask

  task automatic test_byte_load();
    logic r0, er; int rc, wc, bz; logic [31:0] rd, wa, wd;
    do_req(1'b0, 2'b00, 1'b0, 32'h5, 32'h0, r0, rc, rd, er, wc, wa, wd, bz);
    checks++;
    if (rc !== 2 || er !== 1'b0 || rd !== 32'hFFFF_FFAB || wc !== 0) begin
      $display("FAIL lb_signed got cyc=%0d err=%b rd=%h wr=%0d want 2 0 ffffffab 0", rc, er, rd, wc); fails++;
    end
    do_req(1'b0, 2'b00, 1'b1, 32'h5, 32'h0, r0, rc, rd, er, wc, wa, wd, bz);
    checks++;
    if (rc !== 2 || rd !== 32'h0000_00AB) begin
      $display("FAIL lbu got cyc=%0d rd=%h want 2 000000ab", rc, rd); fails++;
    end
    do_req(1'b0, 2'b00, 1'b0, 32'h7, 32'h0, r0, rc, rd, er, wc, wa, wd, bz);
    checks++;
    if (rc !== 2 || rd !== 32'h0000_0011) begin
      $display("FAIL lb_lane3 got cyc=%0d rd=%h want 2 00000011", rc, rd); fails++;
    end
    do_req(1'b0, 2'b00, 1'b1, 32'h4, 32'h0, r0, rc, rd, er, wc, wa, wd, bz);
    checks++;
    if (rc !== 2 || rd !== 32'h0000_0044) begin
      $display("FAIL lbu_lane0 got cyc=%0d rd=%h want 2 00000044", rc, rd); fails++;
    end
  endtask

  task automatic test_halfword();
    logic r0, er; int rc, wc, bz; logic [31:0] rd, wa, wd;
    do_req(1'b0, 2'b01, 1'b0, 32'h6, 32'h0, r0, rc, rd, er, wc, wa, wd, bz);
    checks++;
    if (rc !== 2 || er !== 1'b0 || rd !== 32'h0000_1122) begin
      $display("FAIL lh_hi got cyc=%0d err=%b rd=%h want 2 0 00001122", rc, er, rd); fails++;
    end
    do_req(1'b0, 2'b01, 1'b0, 32'h4, 32'h0, r0, rc, rd, er, wc, wa, wd, bz);
    checks++;
    if (rc !== 2 || rd !== 32'hFFFF_AB44) begin
      $display("FAIL lh_lo_sext got cyc=%0d rd=%h want 2 ffffab44", rc, rd); fails++;
    end
    do_req(1'b1, 2'b01, 1'b0, 32'h6, 32'h0000_BEEF, r0, rc, rd, er, wc, wa, wd, bz);
    checks++;
    if (rc !== 3 || er !== 1'b0 || wc !== 1 || wa !== 32'h4 || wd !== 32'hBEEF_AB44) begin
      $display("FAIL sh_hi got cyc=%0d err=%b n=%0d a=%h wd=%h want 3 0 1 4 beefab44", rc, er, wc, wa, wd); fails++;
    end
    checks++;
    if (mem[1] !== 32'hBEEF_AB44) begin
      $display("FAIL sh_mem got %h want beefab44", mem[1]); fails++;
    end
    do_req(1'b0, 2'b01, 1'b1, 32'h6, 32'h0, r0, rc, rd, er, wc, wa, wd, bz);
    checks++;
    if (rc !== 2 || rd !== 32'h0000_BEEF) begin
      $display("FAIL lhu_hi got cyc=%0d rd=%h want 2 0000beef", rc, rd); fails++;
    end
  endtask

  task automatic test_errors();
    logic r0, er; int rc, wc, bz; logic [31:0] rd, wa, wd;
    do_req(1'b0, 2'b10, 1'b0, 32'h6, 32'h0, r0, rc, rd, er, wc, wa, wd, bz);
    checks++;
    if (rc !== 1 || er !== 1'b1 || rd !== 32'h0 || wc !== 0) begin
      $display("FAIL lw_misal got cyc=%0d err=%b rd=%h wr=%0d want 1 1 0 0", rc, er, rd, wc); fails++;
    end
    do_req(1'b1, 2'b01, 1'b0, 32'h3, 32'h0000_1234, r0, rc, rd, er, wc, wa, wd, bz);
    checks++;
    if (rc !== 1 || er !== 1'b1 || wc !== 0) begin
      $display("FAIL sh_misal got cyc=%0d err=%b wr=%0d want 1 1 0", rc, er, wc); fails++;
    end
    checks++;
    if (mem[0] !== 32'h5A5A_5A00 || mem[1] !== 32'hBEEF_AB44) begin
      $display("FAIL err_mem got %h %h want 5a5a5a00 beefab44", mem[0], mem[1]); fails++;
    end
    do_req(1'b1, 2'b11, 1'b0, 32'h8, 32'h7777_7777, r0, rc, rd, er, wc, wa, wd, bz);
    checks++;
    if (rc !== 1 || er !== 1'b1 || wc !== 0 || mem[2] !== 32'h5A5A_5A02) begin
      $display("FAIL size11 got cyc=%0d err=%b wr=%0d m=%h want 1 1 0 5a5a5a02", rc, er, wc, mem[2]); fails++;
    end
  endtask

  task automatic test_reset_mid();
    int rsp_seen, we_seen;
    rsp_seen = 0; we_seen = 0;
    @(negedge clk);
    bus.req_valid    = 1'b1;
    bus.req_we       = 1'b1;
    bus.req_size     = 2'b10;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = 32'h8;
    bus.req_wdata    = 32'hDEAD_BEEF;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (mem_we !== 1'b1 || mem_a !== 32'h8) begin
      $display("FAIL rm_write got we=%b a=%h want 1 8", mem_we, mem_a); fails++;
    end
    reset            = 1'b1;
    bus.req_valid    = 1'b1;
    bus.req_addr     = 32'hC;
    bus.req_wdata    = 32'h1234_5678;
    #1;
    checks++;
    if (mem_we !== 1'b0 || bus.req_ready !== 1'b0) begin
      $display("FAIL rm_async got we=%b ready=%b want 0 0", mem_we, bus.req_ready); fails++;
    end
    @(posedge clk);
    @(negedge clk);
    reset         = 1'b0;
    bus.req_valid = 1'b0;
    #1;
    checks++;
    if (bus.req_ready !== 1'b1) begin
      $display("FAIL rm_ready got %b want 1", bus.req_ready); fails++;
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (bus.rsp_valid) rsp_seen++;
      if (mem_we) we_seen++;
    end
    checks++;
    if (rsp_seen !== 0 || we_seen !== 0) begin
      $display("FAIL rm_quiet got rsp=%0d we=%0d want 0 0", rsp_seen, we_seen); fails++;
    end
    checks++;
    if (mem[2] !== 32'h5A5A_5A02 || mem[3] !== 32'h5A5A_5A03) begin
      $display("FAIL rm_mem got %h %h want 5a5a5a02 5a5a5a03", mem[2], mem[3]); fails++;
    end
  endtask

  task automatic test_back_to_back();
    logic r0, er; int rc, wc, bz; logic [31:0] rd, wa, wd;
    do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hCAFE_F00D, r0, rc, rd, er, wc, wa, wd, bz);
    checks++;
    if (r0 !== 1'b1 || rc !== 2 || er !== 1'b0 || wc !== 1 || wa !== 32'h10 || wd !== 32'hCAFE_F00D) begin
      $display("FAIL b2b_sw got rdy=%b cyc=%0d err=%b n=%0d a=%h wd=%h want 1 2 0 1 10 cafef00d", r0, rc, er, wc, wa, wd); fails++;
    end
    checks++;
    if (bz !== 0) begin $display("FAIL b2b_sw_busy got %0d want 0", bz); fails++; end
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, r0, rc, rd, er, wc, wa, wd, bz);
    checks++;
    if (r0 !== 1'b1 || rc !== 2 || er !== 1'b0 || rd !== 32'hCAFE_F00D) begin
      $display("FAIL b2b_lw got rdy=%b cyc=%0d err=%b rd=%h want 1 2 0 cafef00d", r0, rc, er, rd); fails++;
    end
    checks++;
    if (bz !== 0 || wc !== 0) begin
      $display("FAIL b2b_lw_busy got busy=%0d wr=%0d want 0 0", bz, wc); fails++;
    end
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    reset            = 1'b1;
    mem_init         = 1'b1;
    bus.req_valid    = 1'b0;
    bus.req_we       = 1'b0;
    bus.req_size     = 2'b00;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = '0;
    bus.req_wdata    = '0;
    repeat (2) @(posedge clk);
    test_reset();
    test_byte_store();
    test_byte_load();
    test_halfword();
    test_errors();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
